// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_scheduler                                               |
// | Purpose  : Round-robin arbiter feeding NUM_PORTS byte requesters into a    |
// |            single UART transmitter (start, 8 data LSB-first, STOP_BITS     |
// |            stop bits, then GAP_BITS idle bit-times).                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   clock, everything on posedge                              |
// |   reset      in   synchronous, active-high                                  |
// |   dbr        in   divisor; bit period = dbr<<4 (0 treated as 16)            |
// |   req_valid  in   per-port byte available                                   |
// |   req_data   in   per-port byte, port k at [8k+7:8k]                        |
// |   req_ready  out  one-hot accept pulse (grant cycle only)                   |
// |   cts        in   clear-to-send, active-low                                 |
// |   txd        out  serial line, idle high                                    |
// |   busy       out  high whenever not idle                                    |
// |   cur_port   out  index of the last granted port                            |
// | Build option                                                               |
// |   UART_TX_SCHED_CTS_GATE_EN : when defined, grants only while cts is low   |
// +----------------------------------------------------------------------------+
module uart_tx_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int STOP_BITS = 3,
  parameter int GAP_BITS  = 10,
  localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            dbr,
  input  logic [NUM_PORTS-1:0]   req_valid,
  input  logic [8*NUM_PORTS-1:0] req_data,
  output logic [NUM_PORTS-1:0]   req_ready,
  input  logic                   cts,
  output logic                   txd,
  output logic                   busy,
  output logic [PW-1:0]          cur_port
);

  localparam int FRAME_BITS = 9 + STOP_BITS;
  localparam int MAX_BITS   = (FRAME_BITS > GAP_BITS) ? FRAME_BITS : GAP_BITS;
  localparam int BCW        = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   winner;
  logic [7:0]      winner_data;
  logic            found;
  logic            grant;
  logic            cts_ok;
  logic [7:0]      shreg;
  logic [31:0]     period;
  logic [31:0]     period_load;
  logic [31:0]     dbr_scaled;
  logic [31:0]     cyc_cnt;
  logic [BCW-1:0]  bit_cnt;
  logic            bit_end;
  logic            last_frame_bit;
  logic            last_gap_bit;

`ifdef UART_TX_SCHED_CTS_GATE_EN
  assign cts_ok = ~cts;
`else
  logic unused_cts;
  assign unused_cts = cts;
  assign cts_ok     = 1'b1;
`endif

  // Period is truncated to 32 bits; a zero result (dbr=0 or only high bits
  // set) would stall the bit counter, so it is replaced by 16.
  assign dbr_scaled  = dbr << 4;
  assign period_load = (dbr_scaled == 32'd0) ? 32'd16 : dbr_scaled;

  assign bit_end        = (cyc_cnt == period - 32'd1);
  assign last_frame_bit = bit_end && (bit_cnt == BCW'(FRAME_BITS - 1));
  assign last_gap_bit   = bit_end && (bit_cnt == BCW'(GAP_BITS - 1));
  assign busy           = (state != IDLE);

  // Round-robin search: the first valid port at or above rr_ptr wins; if none,
  // wrap around and take the lowest valid port.
  always_comb begin
    logic          found_hi, found_lo;
    logic [PW-1:0] win_hi, win_lo;
    logic [7:0]    dat_hi, dat_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    dat_hi   = '0;
    dat_lo   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (req_valid[k] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = PW'(k);
        dat_lo   = req_data[8*k +: 8];
      end
      if (req_valid[k] && (PW'(k) >= rr_ptr) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = PW'(k);
        dat_hi   = req_data[8*k +: 8];
      end
    end
    found       = found_hi | found_lo;
    winner      = found_hi ? win_hi : win_lo;
    winner_data = found_hi ? dat_hi : dat_lo;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (found && cts_ok && !reset) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = SHIFT;
        end
      end
      SHIFT: begin
        if (last_frame_bit) begin
          if (GAP_BITS == 0) state_next = IDLE;
          else               state_next = GAP;
        end
      end
      GAP: begin
        if (last_gap_bit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txd      <= 1'b1;
      cur_port <= '0;
      rr_ptr   <= '0;
      shreg    <= '0;
      period   <= '0;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            shreg    <= winner_data;
            period   <= period_load;
            cur_port <= winner;
            rr_ptr   <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + PW'(1);
            txd      <= 1'b0;
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (bit_end) begin
            cyc_cnt <= '0;
            if (last_frame_bit) begin
              bit_cnt <= '0;
              txd     <= 1'b1;
            end else begin
              // Ones shift in behind the data so the stop bits fall out for free.
              bit_cnt <= bit_cnt + BCW'(1);
              txd     <= shreg[0];
              shreg   <= {1'b1, shreg[7:1]};
            end
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        GAP: begin
          txd <= 1'b1;
          if (bit_end) begin
            cyc_cnt <= '0;
            bit_cnt <= last_gap_bit ? '0 : bit_cnt + BCW'(1);
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end
        default: begin
          txd <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_scheduler                                            |
// | Purpose  : Self-checking bench for uart_tx_scheduler (default build).      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx_scheduler;

  localparam int N    = 4;
  localparam int STOP = 3;
  localparam int GAPB = 10;
  localparam int FB   = 9 + STOP;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [31:0]    dbr = 32'd1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           cts = 1'b0;
  logic           txd;
  logic           busy;
  logic [1:0]     cur_port;

  uart_tx_scheduler #(
    .NUM_PORTS(N),
    .STOP_BITS(STOP),
    .GAP_BITS (GAPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .dbr      (dbr),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .cts      (cts),
    .txd      (txd),
    .busy     (busy),
    .cur_port (cur_port)
  );

  always #5 clk = ~clk;

  int     pass_cnt  = 0;
  int     total_cnt = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  exp_t   sb_q[$];
  longint gtimes[$];

  typedef struct {
    bit          do_rst;
    logic [3:0]  valid;
    logic [31:0] dbr;
    logic [7:0]  data;
    longint      mid;    // dbr value written during data bit 5, -1 for none
    int          port;
    int          p;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Grant monitor: pops the scoreboard on every accept pulse.
  initial begin
    bit   cur_pend;
    int   cur_exp;
    exp_t e;
    cur_pend = 1'b0;
    cur_exp  = 0;
    forever begin
      @(negedge clk);
      if (cur_pend) begin
        chk("cur_port", cur_port, cur_exp);
        cur_pend = 1'b0;
      end
      if (req_ready != '0) begin
        gtimes.push_back(cyc);
        if (sb_q.size() == 0) begin
          chk("unexpected_grant", req_ready, 0);
        end else begin
          e = sb_q.pop_front();
          chk("grant_port", req_ready, longint'(1) << e.port);
          cur_pend = 1'b1;
          cur_exp  = e.port;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset     = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        return;
      end
    end
    total_cnt++;
    $display("FAIL grant_timeout actual=no-grant expected=grant (cycle %0d)", cyc);
  endtask

  // Called at the negedge of the grant cycle; checks every cycle of the frame
  // and the following gap, then the first idle cycle.
  task automatic check_frame(input logic [7:0] d, input int p, input longint mid);
    int   terr, rerr, gerr;
    logic eb;
    terr = 0;
    rerr = 0;
    gerr = 0;
    for (int b = 0; b < FB; b++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        eb = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : 1'b1;
        if (txd !== eb) terr++;
        if (req_ready !== '0 || busy !== 1'b1) rerr++;
        if (mid >= 0 && b == 5 && c == 0) dbr = mid[31:0];
      end
    end
    chk("frame_txd_errors", terr, 0);
    chk("frame_ready_busy_errors", rerr, 0);
    req_valid = '0;
    for (int c = 0; c < GAPB * p; c++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b1 || req_ready !== '0) gerr++;
    end
    chk("gap_errors", gerr, 0);
    @(negedge clk);
    chk("idle_after_gap_busy", busy, 0);
  endtask

  initial begin
    bit         ok;
    logic [7:0] eb;
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    logic [7:0] eb;

    vt[0] = '{1'b1, 4'b0001, 32'd1,          8'hA5, -1, 0, 16};
    vt[1] = '{1'b1, 4'b0110, 32'd2,          8'h3C, -1, 1, 32};
    vt[2] = '{1'b0, 4'b0110, 32'd1,          8'h81, -1, 2, 16};
    vt[3] = '{1'b0, 4'b1001, 32'd1,          8'h0F, -1, 3, 16};
    vt[4] = '{1'b0, 4'b1001, 32'd1,          8'hF0, -1, 0, 16};
    vt[5] = '{1'b1, 4'b1000, 32'h1000_0000,  8'h55, -1, 3, 16};
    vt[6] = '{1'b1, 4'b0001, 32'd0,          8'h5A,  2, 0, 16};
    vt[7] = '{1'b0, 4'b0010, 32'd2,          8'hC3, -1, 1, 32};
    vt[8] = '{1'b0, 4'b1111, 32'd3,          8'h99, -1, 2, 48};

    // Reset state while reset is held.
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_cur_port", cur_port, 0);

    // Table-driven single-frame vectors.
    foreach (vt[i]) begin
      if (vt[i].do_rst) do_reset();
      else step();
      dbr = vt[i].dbr;
      for (int k = 0; k < N; k++) req_data[8*k +: 8] = vt[i].data + 8'(k);
      eb = vt[i].data + 8'(vt[i].port);
      sb_q.push_back('{vt[i].port, eb});
      req_valid = vt[i].valid;
      wait_grant(ok);
      if (ok) check_frame(eb, vt[i].p, vt[i].mid);
    end

    // All ports valid continuously: order 0,1,2,3,0 at 353-cycle spacing.
    do_reset();
    dbr      = 32'd1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    gtimes.delete();
    sb_q.push_back('{0, 8'h11});
    sb_q.push_back('{1, 8'h22});
    sb_q.push_back('{2, 8'h33});
    sb_q.push_back('{3, 8'h44});
    sb_q.push_back('{0, 8'h11});
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) wait_grant(ok);
    step();
    req_valid = '0;
    chk("rr_grant_count", gtimes.size(), 5);
    for (int g = 1; g < gtimes.size(); g++) chk("rr_spacing", gtimes[g] - gtimes[g-1], 353);

    // Single active port (2): granted back-to-back on every IDLE opportunity.
    do_reset();
    gtimes.delete();
    for (int g = 0; g < 3; g++) sb_q.push_back('{2, 8'h33});
    req_valid = 4'b0100;
    for (int g = 0; g < 3; g++) wait_grant(ok);
    step();
    req_valid = '0;
    chk("single_grant_count", gtimes.size(), 3);
    for (int g = 1; g < gtimes.size(); g++) chk("single_spacing", gtimes[g] - gtimes[g-1], 353);

    // Reset in the 5th data bit after granting port 1 (rr_ptr then 2).
    do_reset();
    dbr      = 32'd1;
    req_data = {8'h6E, 8'h6D, 8'h6C, 8'h6B};
    sb_q.push_back('{1, 8'h6C});
    req_valid = 4'b0010;
    wait_grant(ok);
    step();
    req_valid = '0;
    repeat (82) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_txd", txd, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", req_ready, 0);
    chk("midreset_cur_port", cur_port, 0);
    step();
    // Ports 1 and 3 valid: a cleared pointer picks 1, a stale one would pick 3.
    sb_q.push_back('{1, 8'h6C});
    req_valid = 4'b1010;
    wait_grant(ok);
    if (ok) check_frame(8'h6C, 16, -1);

    repeat (3) step();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of byte requesters sharing one UART TX line.
REQ-002 SHALL have parameter STOP_BITS, default 3, stop bits per character.
REQ-003 SHALL have parameter GAP_BITS, default 10, idle bit-times inserted after each character.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port dbr  input  32  divisor; bit period P = dbr<<4, truncated to 32 bits.
REQ-007 SHALL have port req_valid  input  NUM_PORTS  per-port byte-available flag.
REQ-008 SHALL have port req_data  input  8*NUM_PORTS  per-port byte; port k occupies bits [8k+7:8k].
REQ-009 SHALL have port req_ready  output  NUM_PORTS  one-hot accept pulse; the byte transfers when valid and ready are both high.
REQ-010 SHALL have port cts  input  1  clear-to-send, active-low.
REQ-011 SHALL have port txd  output  1  serial output, idle high.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port cur_port  output  clog2(NUM_PORTS), min 1  index of the last granted port.

Function
REQ-014 SHALL implement states IDLE, SHIFT and GAP.
REQ-015 IDLE SHALL grant when any req_valid bit is high: one round-robin winner per grant, search starting at pointer rr_ptr.
REQ-016 On grant, req_ready[winner] SHALL be high for exactly that one cycle; all other ready bits SHALL be 0.
REQ-017 On grant, the block SHALL latch req_data of the winner, P (dbr<<4, with 0 replaced by 16) and cur_port, then move to SHIFT.
REQ-018 On grant, rr_ptr SHALL become (winner+1) mod NUM_PORTS.
REQ-019 Frame format SHALL be: start bit 0, data LSB-first, then STOP_BITS ones; 9+STOP_BITS bits total, each held exactly P cycles.
REQ-020 txd SHALL fall in the cycle after the grant cycle.
REQ-021 After the last stop bit, the block SHALL enter GAP; txd SHALL stay 1 for GAP_BITS*P cycles, then the block SHALL return to IDLE.
REQ-022 IDLE SHALL be able to grant in the cycle it is entered; the minimum grant-to-grant spacing is 1+(9+STOP_BITS+GAP_BITS)*P cycles (22P+1 with defaults).
REQ-023 dbr changes during SHIFT or GAP SHALL be ignored; the new value applies from the next grant.
REQ-024 req_valid changes outside IDLE SHALL have no effect; req_ready SHALL stay 0 outside IDLE.
REQ-025 Ports with req_valid low SHALL be skipped by the search; a single active port SHALL be granted on every IDLE opportunity.
REQ-026 Pointer wrap: rr_ptr SHALL wrap from NUM_PORTS-1 to 0.
REQ-027 Bit and cycle counters SHALL be wide enough for P up to 2^32-1 and for GAP_BITS without overflow.

Reset
REQ-028 reset SHALL take priority over all other activity, including mid-character.
REQ-029 In the cycle after reset is sampled high: state=IDLE, txd=1, busy=0, req_ready=0, cur_port=0, rr_ptr=0, counters=0.
REQ-030 A character cut off by reset SHALL be dropped and not resent.

Configuration
REQ-031 Macro UART_TX_SCHED_CTS_GATE_EN SHALL control CTS gating.
REQ-032 With UART_TX_SCHED_CTS_GATE_EN defined, IDLE SHALL grant only while cts=0; cts rising during SHIFT or GAP SHALL NOT abort the current character.
REQ-033 With UART_TX_SCHED_CTS_GATE_EN undefined, cts SHALL be ignored.

Verification
REQ-034 dbr=1, port 0 valid with data 8'hA5 -> ready0 pulses one cycle; txd from the next cycle = 0,1,0,1,0,0,1,0,1,1,1,1, 16 cycles each, then 160 idle cycles.
REQ-035 dbr=1, all 4 ports valid continuously -> grants in order 0,1,2,3,0, spaced exactly 353 cycles apart; cur_port follows the grant order.
REQ-036 Only port 2 valid, rr_ptr=3 -> port 2 granted; rr_ptr becomes 3; the next grant also goes to port 2.
REQ-037 dbr=0 -> P=16; dbr changed to 2 mid-frame -> the current frame keeps 16-cycle bits and the next frame uses 32-cycle bits.
REQ-038 reset asserted on the 5th data bit -> txd=1 and busy=0 the next cycle; with port 1 valid after reset, port 0 is searched first and port 1 is granted.
REQ-039 Macro defined, cts=1, port 0 valid -> no grant; cts set to 0 -> grant in that cycle; cts=1 mid-frame -> frame completes.
